// File: rtl/traffic_phase_controller.sv
// Round-robin traffic phase sequencer: GREEN -> YELLOW -> ALL-RED per approach,
// with pedestrian green extension and emergency preemption.
module traffic_phase_controller #(
    parameter int NUM_PHASES  = 4,
    parameter int GREEN_CYC   = 20,
    parameter int YELLOW_CYC  = 5,
    parameter int ALLRED_CYC  = 2,
    parameter int PED_EXT_CYC = 10,
    parameter int CNT_W       = 8,
    parameter int PH_W        = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PHASES-1:0]   ped_req,
    input  logic                    emerg_req,
    input  logic [PH_W-1:0]         emerg_phase,
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         active_phase,
    output logic [NUM_PHASES-1:0]   ped_walk,
    output logic                    preempt_act
);

    typedef enum logic [1:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_PREEMPT
    } state_t;

    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_GREEN  = 2'b01;
    localparam logic [1:0] L_YELLOW = 2'b10;

    localparam logic [CNT_W-1:0] T_GREEN     = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] T_GREEN_EXT = CNT_W'(GREEN_CYC + PED_EXT_CYC - 1);
    localparam logic [CNT_W-1:0] T_YELLOW    = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] T_ALLRED    = CNT_W'(ALLRED_CYC - 1);
    localparam logic [PH_W:0]    NP_W        = (PH_W + 1)'(NUM_PHASES);

    state_t                  state;
    logic [CNT_W-1:0]        timer;
    logic                    first;
    logic [NUM_PHASES-1:0]   ped_latch;

    logic [PH_W-1:0]         e_ph;
    logic [PH_W-1:0]         rot_ph;
    logic [PH_W-1:0]         tgt;

    function automatic logic [2*NUM_PHASES-1:0] lamp(input logic [PH_W-1:0] p,
                                                      input logic [1:0] code);
        logic [2*NUM_PHASES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == p) v[2*i +: 2] = code;
        end
        return v;
    endfunction

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PH_W-1:0] p);
        logic [NUM_PHASES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == p) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Out-of-range emergency phases fall back to phase 0
    assign e_ph   = ({1'b0, emerg_phase} >= NP_W) ? '0 : emerg_phase;
    assign rot_ph = ({1'b0, active_phase} == NP_W - 1'b1) ? '0
                                                          : active_phase + 1'b1;
    assign tgt    = first ? '0 : rot_ph;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ALLRED;
            timer        <= T_ALLRED;
            first        <= 1'b1;
            ped_latch    <= '0;
            lights       <= '0;
            active_phase <= '0;
            ped_walk     <= '0;
            preempt_act  <= 1'b0;
        end else begin
            ped_latch <= ped_latch | ped_req;
            unique case (state)
                S_ALLRED: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (emerg_req) begin
                        state        <= S_PREEMPT;
                        first        <= 1'b0;
                        active_phase <= e_ph;
                        lights       <= lamp(e_ph, L_GREEN);
                        ped_walk     <= '0;
                        preempt_act  <= 1'b1;
                    end else begin
                        state        <= S_GREEN;
                        first        <= 1'b0;
                        active_phase <= tgt;
                        lights       <= lamp(tgt, L_GREEN);
                        if (ped_latch[tgt]) begin
                            timer     <= T_GREEN_EXT;
                            ped_walk  <= onehot(tgt);
                            // A fresh press in this cycle re-arms the latch
                            ped_latch <= (ped_latch & ~onehot(tgt)) | ped_req;
                        end else begin
                            timer    <= T_GREEN;
                            ped_walk <= '0;
                        end
                    end
                end
                S_GREEN: begin
                    if (emerg_req && active_phase == e_ph) begin
                        state       <= S_PREEMPT;
                        ped_walk    <= '0;
                        preempt_act <= 1'b1;
                    end else if (emerg_req || timer == '0) begin
                        state    <= S_YELLOW;
                        timer    <= T_YELLOW;
                        lights   <= lamp(active_phase, L_YELLOW);
                        ped_walk <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (timer == '0) begin
                        state  <= S_ALLRED;
                        timer  <= T_ALLRED;
                        lights <= lamp(active_phase, L_RED);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_PREEMPT: begin
                    if (!emerg_req) begin
                        state       <= S_YELLOW;
                        timer       <= T_YELLOW;
                        lights      <= lamp(active_phase, L_YELLOW);
                        preempt_act <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: rotation, ped extension,
// preemption and mid-run reset, with hand-computed expectations.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ped_req;
    logic       emerg_req;
    logic [1:0] emerg_phase;
    logic [7:0] lights;
    logic [1:0] active_phase;
    logic [3:0] ped_walk;
    logic       preempt_act;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    traffic_phase_controller #(
        .NUM_PHASES (4),
        .GREEN_CYC  (4),
        .YELLOW_CYC (2),
        .ALLRED_CYC (1),
        .PED_EXT_CYC(3),
        .CNT_W      (8),
        .PH_W       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ped_req     (ped_req),
        .emerg_req   (emerg_req),
        .emerg_phase (emerg_phase),
        .lights      (lights),
        .active_phase(active_phase),
        .ped_walk    (ped_walk),
        .preempt_act (preempt_act)
    );

    always #5 clk = ~clk;

    // Undisturbed rotation: cycle 1 all-red, then 7-cycle slots per phase
    function automatic logic [7:0] norm_lights(input int c);
        int m, ph, r;
        if (c == 1) return 8'h00;
        m  = (c - 2) % 28;
        ph = m / 7;
        r  = m % 7;
        if (r < 4) return 8'h01 << (2 * ph);
        if (r < 6) return 8'h02 << (2 * ph);
        return 8'h00;
    endfunction

    function automatic logic [1:0] norm_phase(input int c);
        if (c == 1) return 2'd0;
        return 2'(((c - 2) % 28) / 7);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        ped_req = '0;
        emerg_req = 1'b0;
        emerg_phase = '0;
        step();
        checks++;
        if (lights !== 8'h00 || active_phase !== 2'd0 ||
            ped_walk !== 4'h0 || preempt_act !== 1'b0) begin
            failures++;
            $display("FAIL %s: lights=%h ph=%0d walk=%b pre=%b, want 00 0 0000 0",
                     tag, lights, active_phase, ped_walk, preempt_act);
        end
        rst = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        reset_and_check("reset_values");
    endtask

    task automatic test_rotation();
        int nr;
        logic bad;
        reset_and_check("rotation_reset");
        for (int c = 1; c <= 60; c++) begin
            run_to(c);
            checks++;
            if (lights !== norm_lights(cyc)) begin
                failures++;
                $display("FAIL rotation_lights cyc%0d: got %h want %h",
                         cyc, lights, norm_lights(cyc));
            end
            checks++;
            if (active_phase !== norm_phase(cyc)) begin
                failures++;
                $display("FAIL rotation_phase cyc%0d: got %0d want %0d",
                         cyc, active_phase, norm_phase(cyc));
            end
            nr = 0;
            bad = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (lights[2*i +: 2] != 2'b00) nr++;
                if (lights[2*i +: 2] == 2'b11) bad = 1'b1;
            end
            checks++;
            if (nr > 1 || bad) begin
                failures++;
                $display("FAIL one_nonred cyc%0d: lights=%h", cyc, lights);
            end
        end
    endtask

    task automatic test_ped_extend();
        int g1 = 0, w1 = 0, g2 = 0, w2 = 0;
        reset_and_check("ped_reset");
        run_to(3);
        ped_req = 4'b0100;
        step();
        ped_req = '0;
        while (cyc <= 52) begin
            if (lights === 8'h10) begin
                if (cyc < 36) begin
                    g1++;
                    if (ped_walk === 4'b0100) w1++;
                end else begin
                    g2++;
                end
            end
            if (cyc >= 36 && ped_walk !== 4'h0) w2++;
            if (cyc == 23) begin
                checks++;
                if (lights !== 8'h20) begin
                    failures++;
                    $display("FAIL ped_yellow_after_ext: got %h want 20", lights);
                end
            end
            step();
        end
        checks++;
        if (g1 != 7) begin
            failures++;
            $display("FAIL ped_green_len: got %0d want 7", g1);
        end
        checks++;
        if (w1 != 7) begin
            failures++;
            $display("FAIL ped_walk_len: got %0d want 7", w1);
        end
        checks++;
        if (g2 != 4) begin
            failures++;
            $display("FAIL ped_next_green_len: got %0d want 4", g2);
        end
        checks++;
        if (w2 != 0) begin
            failures++;
            $display("FAIL ped_walk_next_rot: got %0d cycles want 0", w2);
        end
    endtask

    task automatic test_preempt_other();
        int n = 0;
        logic [7:0] exp_l [4] = '{8'h08, 8'h08, 8'h00, 8'h40};
        reset_and_check("pre_other_reset");
        run_to(11);
        emerg_req = 1'b1;
        emerg_phase = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (lights !== exp_l[k]) begin
                failures++;
                $display("FAIL pre_other_seq cyc%0d: got %h want %h",
                         cyc, lights, exp_l[k]);
            end
        end
        for (int k = 0; k < 20; k++) begin
            if (lights === 8'h40 && preempt_act === 1'b1 &&
                active_phase === 2'd3) n++;
            if (k == 19) emerg_req = 1'b0;
            step();
        end
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL pre_other_hold: got %0d cycles want 20", n);
        end
        checks++;
        if (lights !== 8'h80 || preempt_act !== 1'b0) begin
            failures++;
            $display("FAIL pre_other_exit_yel: got %h/%b want 80/0",
                     lights, preempt_act);
        end
        run_to(37);
        checks++;
        if (lights !== 8'h00) begin
            failures++;
            $display("FAIL pre_other_allred: got %h want 00", lights);
        end
        step();
        checks++;
        if (lights !== 8'h01 || active_phase !== 2'd0) begin
            failures++;
            $display("FAIL pre_other_resume: got %h ph%0d want 01 ph0",
                     lights, active_phase);
        end
        run_to(42);
        checks++;
        if (lights !== 8'h02) begin
            failures++;
            $display("FAIL pre_other_resume_len: got %h want 02", lights);
        end
    endtask

    task automatic test_preempt_same();
        int n = 0;
        reset_and_check("pre_same_reset");
        run_to(9);
        emerg_req = 1'b1;
        emerg_phase = 2'd1;
        step();
        checks++;
        if (preempt_act !== 1'b1 || lights !== 8'h04) begin
            failures++;
            $display("FAIL pre_same_entry: got %h/%b want 04/1",
                     lights, preempt_act);
        end
        run_to(12);
        emerg_phase = 2'd3;
        ped_req = 4'b0010;
        step();
        ped_req = '0;
        for (int k = 0; k < 8; k++) begin
            if (lights === 8'h04 && preempt_act === 1'b1 &&
                active_phase === 2'd1 && ped_walk === 4'h0) n++;
            if (k == 7) emerg_req = 1'b0;
            step();
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL pre_same_hold: got %0d cycles want 8", n);
        end
        checks++;
        if (lights !== 8'h08 || preempt_act !== 1'b0) begin
            failures++;
            $display("FAIL pre_same_exit: got %h/%b want 08/0",
                     lights, preempt_act);
        end
        run_to(24);
        checks++;
        if (lights !== 8'h10 || active_phase !== 2'd2) begin
            failures++;
            $display("FAIL pre_same_resume: got %h ph%0d want 10 ph2",
                     lights, active_phase);
        end
        run_to(45);
        checks++;
        if (lights !== 8'h04 || ped_walk !== 4'b0010) begin
            failures++;
            $display("FAIL pre_latch_walk: got %h/%b want 04/0010",
                     lights, ped_walk);
        end
        run_to(51);
        checks++;
        if (lights !== 8'h04) begin
            failures++;
            $display("FAIL pre_latch_ext: got %h want 04", lights);
        end
        step();
        checks++;
        if (lights !== 8'h08 || ped_walk !== 4'h0) begin
            failures++;
            $display("FAIL pre_latch_end: got %h/%b want 08/0000",
                     lights, ped_walk);
        end
    endtask

    task automatic test_ped_entry_race();
        reset_and_check("race_reset");
        run_to(2);
        ped_req = 4'b0010;
        step();
        ped_req = '0;
        run_to(8);
        ped_req = 4'b0010;
        step();
        ped_req = '0;
        checks++;
        if (lights !== 8'h04 || ped_walk !== 4'b0010) begin
            failures++;
            $display("FAIL race_entry: got %h/%b want 04/0010", lights, ped_walk);
        end
        run_to(15);
        checks++;
        if (lights !== 8'h04) begin
            failures++;
            $display("FAIL race_ext1: got %h want 04", lights);
        end
        step();
        checks++;
        if (lights !== 8'h08) begin
            failures++;
            $display("FAIL race_ext1_end: got %h want 08", lights);
        end
        run_to(40);
        checks++;
        if (lights !== 8'h04 || ped_walk !== 4'b0010) begin
            failures++;
            $display("FAIL race_ext2: got %h/%b want 04/0010", lights, ped_walk);
        end
        run_to(47);
        checks++;
        if (lights !== 8'h08) begin
            failures++;
            $display("FAIL race_ext2_end: got %h want 08", lights);
        end
        run_to(71);
        checks++;
        if (lights !== 8'h04 || ped_walk !== 4'h0) begin
            failures++;
            $display("FAIL race_third: got %h/%b want 04/0000", lights, ped_walk);
        end
        run_to(75);
        checks++;
        if (lights !== 8'h08) begin
            failures++;
            $display("FAIL race_third_len: got %h want 08", lights);
        end
    endtask

    task automatic check_restart(input string tag);
        for (int c = 1; c <= 13; c++) begin
            run_to(c);
            checks++;
            if (lights !== norm_lights(cyc) || active_phase !== norm_phase(cyc)) begin
                failures++;
                $display("FAIL %s cyc%0d: got %h ph%0d want %h ph%0d", tag, cyc,
                         lights, active_phase, norm_lights(cyc), norm_phase(cyc));
            end
        end
    endtask

    task automatic test_mid_reset();
        reset_and_check("mid_reset_init");
        run_to(6);
        checks++;
        if (lights !== 8'h02) begin
            failures++;
            $display("FAIL mid_yellow_setup: got %h want 02", lights);
        end
        reset_and_check("mid_reset_yellow");
        check_restart("restart_after_yellow");
        reset_and_check("mid_reset_init2");
        run_to(2);
        ped_req = 4'b0010;
        step();
        ped_req = '0;
        emerg_req = 1'b1;
        emerg_phase = 2'd2;
        run_to(7);
        checks++;
        if (lights !== 8'h10 || preempt_act !== 1'b1 || active_phase !== 2'd2) begin
            failures++;
            $display("FAIL mid_preempt_setup: got %h/%b ph%0d want 10/1 ph2",
                     lights, preempt_act, active_phase);
        end
        reset_and_check("mid_reset_preempt");
        check_restart("restart_after_preempt");
    endtask

    initial begin
        rst = 1'b1;
        ped_req = '0;
        emerg_req = 1'b0;
        emerg_phase = '0;
        test_reset();
        test_rotation();
        test_ped_extend();
        test_preempt_other();
        test_preempt_same();
        test_ped_entry_race();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
